// File: rtl/key_freq_ctrl_mc.sv
// key_freq_ctrl_mc
//   Key-adjustable blink controller for N_CH channels, with an 8-digit
//   multiplexed 7-segment readout. The readout shows the selected channel's
//   blink frequency in Hz x100, formatted as dd.dd. All logic runs on clk and
//   advances on 1-cycle tick enables. No derived clocks are used.
//
// Ports
//   clk     system clock
//   rst     asynchronous, active-high reset
//   key_up  active-low key, shortens the selected channel's half-period
//   key_dn  active-low key, lengthens the selected channel's half-period
//   key_ch  active-low key, advances the selected channel
//   led     blink outputs, one per channel
//   cs      digit select, one-hot active-low
//   seg     segments, active-low, {dp, g, f, e, d, c, b, a}
//   ch_sel  currently selected channel
//
// Compute FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting; leaves at once when a recompute is pending
//   S_LOAD   | latch period[sel], preload dividend, clear remainder/BCD
//   S_DIV    | restoring divide, one quotient bit per cycle (DW cycles)
//   S_BCD    | double-dabble, one shift per cycle (DW cycles)
//   S_COMMIT | copy the four BCD digits into the display register
module key_freq_ctrl_mc #(
  parameter int F_CLK    = 50000000,
  parameter int F_TICK   = 1000,
  parameter int N_CH     = 4,
  parameter int STEP     = 50,
  parameter int P_MIN    = 50,
  parameter int P_MAX    = 1000,
  parameter int P_RST    = 1000,
  parameter int RPT_DLY  = 500,
  parameter int RPT_RATE = 100,
  localparam int SW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_up,
  input  logic            key_dn,
  input  logic            key_ch,
  output logic [N_CH-1:0] led,
  output logic [7:0]      cs,
  output logic [7:0]      seg,
  output logic [SW-1:0]   ch_sel
);

  localparam int TICK_DIV = F_CLK / F_TICK;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW       = $clog2(P_MAX + 1);
  localparam int DVD      = F_TICK * 50;
  localparam int DW       = $clog2(DVD + 1);
  localparam int CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam int RMAX     = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
  localparam int RW       = $clog2(RMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_BCD, S_COMMIT} state_t;

  // tick generator
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // key synchronizers: [0],[1] form the 2-FF sync, [2] holds the previous
  // synchronized level for falling-edge detection. Idle level is high.
  logic [2:0] up_sr, dn_sr, ch_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sr <= '1;
      dn_sr <= '1;
      ch_sr <= '1;
    end else begin
      up_sr <= {up_sr[1:0], key_up};
      dn_sr <= {dn_sr[1:0], key_dn};
      ch_sr <= {ch_sr[1:0], key_ch};
    end
  end

  logic [1:0] kp_press, kp_held, kp_fire;
  logic       ch_press;

  assign kp_press = {dn_sr[2] & ~dn_sr[1], up_sr[2] & ~up_sr[1]};
  assign kp_held  = {~dn_sr[1], ~up_sr[1]};
  assign ch_press = ch_sr[2] & ~ch_sr[1];

  // auto-repeat down-counters for up [0] and dn [1]; a press loads the
  // initial delay, each terminal count fires and reloads the repeat interval
  logic [RW-1:0] rpt_cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt[0] <= '0;
      rpt_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (kp_press[i])
          rpt_cnt[i] <= RW'(RPT_DLY);
        else if (tick && kp_held[i])
          rpt_cnt[i] <= (rpt_cnt[i] == RW'(1)) ? RW'(RPT_RATE) : rpt_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    kp_fire = '0;
    for (int i = 0; i < 2; i++)
      kp_fire[i] = tick & kp_held[i] & ~kp_press[i] & (rpt_cnt[i] == RW'(1));
  end

  logic ev_up, ev_dn;

  assign ev_up = kp_press[0] | kp_fire[0];
  assign ev_dn = kp_press[1] | kp_fire[1];

  // channel select and per-channel half-periods
  logic [SW-1:0] sel;
  logic [PW-1:0] period [N_CH];
  logic [PW-1:0] per_cur, per_dec, per_inc;
  logic [PW:0]   per_ext, per_sum;

  assign per_cur = period[sel];
  assign per_ext = {1'b0, per_cur};
  assign per_sum = per_ext + (PW+1)'(STEP);
  assign per_dec = (per_ext < (PW+1)'(P_MIN + STEP)) ? PW'(P_MIN)
                                                     : PW'(per_ext - (PW+1)'(STEP));
  assign per_inc = (per_sum > (PW+1)'(P_MAX)) ? PW'(P_MAX) : per_sum[PW-1:0];

  // simultaneous up and dn cancel; a coincident ch press still uses the old sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
      for (int i = 0; i < N_CH; i++) period[i] <= PW'(P_RST);
    end else begin
      if (ev_up ^ ev_dn) period[sel] <= ev_up ? per_dec : per_inc;
      if (ch_press)      sel <= (sel == SW'(N_CH - 1)) ? '0 : sel + 1'b1;
    end
  end

  assign ch_sel = sel;

  // blink channels
  logic [PW-1:0] bcnt [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
      for (int i = 0; i < N_CH; i++) bcnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        if (bcnt[i] >= period[i] - 1'b1) begin
          bcnt[i] <= '0;
          led[i]  <= ~led[i];
        end else begin
          bcnt[i] <= bcnt[i] + 1'b1;
        end
      end
    end
  end

  // recompute trigger: the displayed operand (sel or its period) moved
  logic [SW-1:0] sel_q;
  logic [PW-1:0] per_q;
  logic          trig, pend;
  state_t        state, state_nxt;

  assign trig = (sel != sel_q) | (per_cur != per_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      per_q <= PW'(P_RST);
      pend  <= 1'b1;
    end else begin
      sel_q <= sel;
      per_q <= per_cur;
      pend  <= trig | (pend & (state != S_IDLE));
    end
  end

  // compute FSM
  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pend) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_DIV;
      S_DIV:    if (bit_cnt == '0) state_nxt = S_BCD;
      S_BCD:    if (bit_cnt == '0) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  logic ld_en, div_en, bcd_en, cmt_en;

  always_comb begin
    ld_en  = 1'b0;
    div_en = 1'b0;
    bcd_en = 1'b0;
    cmt_en = 1'b0;
    case (state)
      S_LOAD:   ld_en  = 1'b1;
      S_DIV:    div_en = 1'b1;
      S_BCD:    bcd_en = 1'b1;
      S_COMMIT: cmt_en = 1'b1;
      default:  ;
    endcase
  end

  // datapath: quo holds the dividend while dividing (quotient bits shift in
  // from the right) and is then shifted out MSB-first into the BCD register
  logic [PW-1:0] divisor, rem;
  logic [DW-1:0] quo;
  logic [15:0]   bcd, bcd_adj, disp;
  logic [PW:0]   div_sh, div_sub;
  logic          div_ge;

  assign div_sh  = {rem, quo[DW-1]};
  assign div_ge  = (div_sh >= {1'b0, divisor});
  assign div_sub = div_sh - {1'b0, divisor};

  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 4; n++)
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '0;
    end else begin
      if (ld_en) begin
        divisor <= per_cur;
        rem     <= '0;
        quo     <= DW'(DVD);
        bcd     <= '0;
        bit_cnt <= CW'(DW - 1);
      end
      if (div_en) begin
        rem     <= div_ge ? div_sub[PW-1:0] : div_sh[PW-1:0];
        quo     <= {quo[DW-2:0], div_ge};
        bit_cnt <= (bit_cnt == '0) ? CW'(DW - 1) : bit_cnt - 1'b1;
      end
      if (bcd_en) begin
        bcd     <= {bcd_adj[14:0], quo[DW-1]};
        quo     <= {quo[DW-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (cmt_en) disp <= bcd;
    end
  end

  // scan: glyphs are active-low gfedcba
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  logic [2:0] dig_idx;
  logic [7:0] seg_nxt;

  always_comb begin
    seg_nxt = 8'hFF;
    case (dig_idx)
      3'd0:    seg_nxt = {1'b1, glyph(4'(sel))};
      3'd4:    seg_nxt = {1'b1, glyph(disp[15:12])};
      3'd5:    seg_nxt = {1'b0, glyph(disp[11:8])};
      3'd6:    seg_nxt = {1'b1, glyph(disp[7:4])};
      3'd7:    seg_nxt = {1'b1, glyph(disp[3:0])};
      default: seg_nxt = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_idx <= '0;
      cs      <= 8'hFF;
      seg     <= 8'hFF;
    end else if (tick) begin
      cs      <= ~(8'd1 << dig_idx);
      seg     <= seg_nxt;
      dig_idx <= dig_idx + 1'b1;
    end
  end

endmodule
